mbinit_reversalmb_partner: RTL

Partner-side (responder) sequencer for the MBINIT.REVERSALMB step of link training, sitting directly upstream of the REPAIRMB partner stage. It answers the remote initiator's REVERSALMB sideband requests, clears and arms the receive-side per-lane pattern comparator, and returns the 16-bit per-lane pass/fail vector. Its end flag is the enable consumed by the REPAIRMB partner stage.

---
 rtl/mbinit_reversalmb_partner.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mbinit_reversalmb_partner.sv
// MBINIT.REVERSALMB partner-side sequencer: answers the initiator's sideband
// requests, clears/arms the lane comparator and returns the per-lane result.
module mbinit_reversalmb_partner (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        i_MBINIT_REPAIRVAL_end,
    input  logic        i_Busy_SideBand,
    input  logic        i_falling_edge_busy,
    input  logic [3:0]  i_RX_SbMessage,
    input  logic        i_msg_valid,
    input  logic        i_compare_done,
    input  logic [15:0] i_lane_result,
    output logic        o_clear_error,
    output logic        o_compare_en,
    output logic [3:0]  o_TX_SbMessage,
    output logic [15:0] o_TX_data,
    output logic        o_ValidOutData,
    output logic        o_MBINIT_REVERSALMB_end
);

    localparam logic [3:0] MsgInitReq      = 4'b0001;
    localparam logic [3:0] MsgInitResp     = 4'b0010;
    localparam logic [3:0] MsgClearErrReq  = 4'b0011;
    localparam logic [3:0] MsgClearErrResp = 4'b0100;
    localparam logic [3:0] MsgResultReq    = 4'b0101;
    localparam logic [3:0] MsgResultResp   = 4'b0110;
    localparam logic [3:0] MsgDoneReq      = 4'b0111;
    localparam logic [3:0] MsgDoneResp     = 4'b1000;

    typedef enum logic [3:0] {
        StIdle, StWaitInit, StBusyInit, StSendInit, StWaitClr, StBusyClr, StSendClr,
        StCompare, StFlush, StBusyRes, StSendRes, StWaitNext, StBusyDone, StSendDone, StDone
    } state_e;

    state_e      r_cs;
    state_e      w_ns;
    logic        r_clear_error;
    logic        r_compare_en;
    logic [3:0]  r_tx_msg;
    logic [15:0] r_tx_data;
    logic        r_valid;
    logic        r_end;

    logic w_init_req;
    logic w_clr_req;
    logic w_res_req;
    logic w_done_req;

    assign w_init_req = i_msg_valid && (i_RX_SbMessage == MsgInitReq);
    assign w_clr_req  = i_msg_valid && (i_RX_SbMessage == MsgClearErrReq);
    assign w_res_req  = i_msg_valid && (i_RX_SbMessage == MsgResultReq);
    assign w_done_req = i_msg_valid && (i_RX_SbMessage == MsgDoneReq);

    // Next-state decode; a low enable overrides everything and returns to idle.
    always_comb begin
        w_ns = r_cs;
        case (r_cs)
            StIdle:     w_ns = StWaitInit;
            StWaitInit: if (w_init_req) w_ns = StBusyInit;
            StBusyInit: if (!i_Busy_SideBand) w_ns = StSendInit;
            StSendInit: if (i_falling_edge_busy) w_ns = StWaitClr;
            StWaitClr:  if (w_clr_req) w_ns = StBusyClr;
            StBusyClr:  if (!i_Busy_SideBand) w_ns = StSendClr;
            StSendClr:  if (i_falling_edge_busy) w_ns = StCompare;
            StCompare:  if (w_res_req) w_ns = StFlush;
            StFlush:    if (i_compare_done) w_ns = StBusyRes;
            StBusyRes:  if (!i_Busy_SideBand) w_ns = StSendRes;
            StSendRes:  if (i_falling_edge_busy) w_ns = StWaitNext;
            StWaitNext: begin
                if (w_clr_req) begin
                    w_ns = StBusyClr;
                end else if (w_done_req) begin
                    w_ns = StBusyDone;
                end
            end
            StBusyDone: if (!i_Busy_SideBand) w_ns = StSendDone;
            StSendDone: if (i_falling_edge_busy) w_ns = StDone;
            StDone:     w_ns = StDone;
            default:    w_ns = StIdle;
        endcase
        if (!i_MBINIT_REPAIRVAL_end) begin
            w_ns = StIdle;
        end
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_cs          <= StIdle;
            r_clear_error <= 1'b0;
            r_compare_en  <= 1'b0;
            r_tx_msg      <= 4'h0;
            r_tx_data     <= 16'h0000;
            r_valid       <= 1'b0;
            r_end         <= 1'b0;
        end else begin
            r_cs          <= w_ns;
            r_clear_error <= 1'b0;
            r_valid       <= 1'b0;
            r_tx_msg      <= 4'h0;
            r_compare_en  <= (w_ns == StCompare);
            r_end         <= (w_ns == StDone);
            // Strobe only on entry so a long SEND_* never repeats the message.
            if (r_cs != w_ns) begin
                case (w_ns)
                    StSendInit: begin
                        r_valid  <= 1'b1;
                        r_tx_msg <= MsgInitResp;
                    end
                    StSendClr: begin
                        r_valid       <= 1'b1;
                        r_tx_msg      <= MsgClearErrResp;
                        r_clear_error <= 1'b1;
                    end
                    StSendRes: begin
                        r_valid  <= 1'b1;
                        r_tx_msg <= MsgResultResp;
                    end
                    StSendDone: begin
                        r_valid  <= 1'b1;
                        r_tx_msg <= MsgDoneResp;
                    end
                    default: ;
                endcase
            end
            if ((r_cs == StFlush) && (w_ns == StBusyRes)) begin
                r_tx_data <= i_lane_result;
            end
        end
    end

    assign o_clear_error           = r_clear_error;
    assign o_compare_en            = r_compare_en;
    assign o_TX_SbMessage          = r_tx_msg;
    assign o_TX_data               = r_tx_data;
    assign o_ValidOutData          = r_valid;
    assign o_MBINIT_REVERSALMB_end = r_end;

endmodule
